seg_mux_driver: RTL and testbench
=================================

# seg_mux_driver

Parametrised N-digit multiplexed seven-segment display driver with an internal clock-enable prescaler, anti-ghosting blanking interval, per-digit decimal points, leading-zero blanking, and tear-free double-buffered loading via a valid/ready handshake. It replaces the fixed four-digit feeder/decoder pair and the DCM-derived slow clock. Everything runs on the single board clock. It sits between any data producer (counter, UART, debug register) and the board's anode/segment pins.

## Interface
- DIGITS, 4: number of digits. Digit 0 is the rightmost and drives an[0]. Must be ≥1.
- PRESCALE, 1024: clk cycles per digit slot. Must be ≥2 and > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes inactive.
- AN_ACTIVE_LOW, 1: anode polarity (1 means 0 lights the digit).
- SEG_ACTIVE_LOW, 1: segment and dp polarity.

Ports:
- clk  in  1  board clock.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  producer offers a new display word.
- load_ready  out  1  driver can accept a word; equals !pending.
- load_data  in  4*DIGITS  hex nibbles; nibble i maps to digit i.
- load_dp  in  DIGITS  decimal point per digit; 1 means lit.
- lzb_en  in  1  leading-zero blanking enable, sampled continuously.
- brightness  in  4  dimming level, 15 is full. Present only with SEGMUX_DIMMING_EN.
- an  out  DIGITS  anode enables.
- seg  out  7  segments; seg[6]=a … seg[0]=g.
- dp  out  1  decimal point.
- frame_tick  out  1  one-cycle pulse marking the end of the last digit's slot.

## Operation
- **Counters:** slot_cnt runs 0..PRESCALE-1 and wraps. digit_idx advances when slot_cnt wraps, and wraps DIGITS-1 → 0.
- **Lit window:** the current digit is lit while slot_cnt ≥ BLANK_CYCLES. Otherwise all anodes are inactive. Segments are always driven from the current digit.
- **Buffering:** load_data and load_dp are captured into a shadow buffer when load_valid && load_ready, which sets pending.
- **Commit:** on the cycle where digit_idx=DIGITS-1 and slot_cnt=PRESCALE-1, a pending shadow is copied to the active buffer and pending clears.
- **Accept on a commit cycle:** the commit uses registered pending, so a word accepted on that cycle stays in the shadow until the next frame end.
- **Decode:** hex 0–F uses the standard table (b=c only for 1; A,b,C,d,E,F for 10–15).
- **Leading-zero blanking (lzb_en=1):** digits from DIGITS-1 downward whose nibble is 0 are segment-blanked until the first nonzero nibble. Digit 0 is never blanked. dp is unaffected by blanking.
- **Polarity:** applied at the output registers only.
- **Reset:** asynchronous. It clears both counters, both buffers, and pending. Outputs go inactive immediately: an all off, seg all off, dp off, frame_tick=0, load_ready=1. A reset mid-frame discards any pending word.

## Timing
- an, seg, dp and frame_tick are registered with one cycle of latency from counter state.
- Edge n after reset release (n=1 is the first edge) reflects counter state n-1: slot = (n-1) mod PRESCALE, digit = ((n-1) div PRESCALE) mod DIGITS.
- frame_tick is high at edges n = k·PRESCALE·DIGITS, k ≥ 1.
- Committed data first appears on the pins in the next digit-0 lit window.
- load_ready falls on the edge after acceptance. It rises on the edge after commit (same edge as frame_tick).
- Counter width is $clog2(PRESCALE) and digit index width is $clog2(DIGITS), minimum 1. Neither counter may overflow before its wrap compare.

## Configuration
- SEGMUX_DIMMING_EN defined:
  - the brightness port exists;
  - the lit window is shortened to ((PRESCALE-BLANK_CYCLES)·(brightness+1))>>4 cycles starting at slot_cnt=BLANK_CYCLES;
  - brightness=15 gives the full window.
- Undefined: no brightness port, full lit window.

## Structure
- Package seg_mux_pkg holds:
  - the 7-bit segment encoding localparams, with SEG_BLANK = 7'b0000000 active-high;
  - the hex-to-segment function;
  - the polarity helper.
- Sub-module seg7_hex_decode is combinational: nibble and blank in, active-high seg out. It is instantiated once on the muxed digit.

## Test plan
Parameters are DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, active-low outputs unless stated.
- **Reset:** hold reset=0 for 5 cycles, with clk running → an=4'b1111, seg=7'h7F, dp=1, load_ready=1, frame_tick=0 throughout.
- **Scan:**
  - release reset → an=4'b1110 on edges 3–8;
  - 4'b1111 on edges 9–10;
  - 4'b1101 on edges 11–16;
  - frame_tick=1 only at edge 32.
- **Load and commit:**
  - at edge 12, load_data=16'h12AF, load_dp=4'b0100, valid=1 for one cycle → load_ready=0 from edge 13;
  - pins keep showing 0000 until frame_tick;
  - from edge 35, digit 0 seg=7'b0111000 (F);
  - digit 2 shows 2 with dp=0;
  - load_ready=1 from edge 32.
- **Leading-zero blanking:** commit 16'h0070 with lzb_en=1 → digits 3 and 2 seg=7'h7F, digit 1 shows 7 (7'b0001111), digit 0 shows 0 (7'b0000001).
- **Reset mid-operation:** with a pending word, pulse reset low at edge 20 → all outputs inactive that cycle; after release the display shows 0000 and load_ready=1.
- **Dimming:** with SEGMUX_DIMMING_EN, PRESCALE=34, BLANK_CYCLES=2, brightness=7 → each anode is active for exactly 16 consecutive cycles per slot.

Source files
------------

// File: rtl/seg_mux_pkg.sv
// Shared segment encodings, hex decode and polarity helpers for the multiplexed 7-segment driver.
// Segment bit order is {a,b,c,d,e,f,g}; all encodings here are active-high.
package seg_mux_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b1000111;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nib);
    logic [SEG_W-1:0] s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = SEG_HEX_0;
      4'h1: s = SEG_HEX_1;
      4'h2: s = SEG_HEX_2;
      4'h3: s = SEG_HEX_3;
      4'h4: s = SEG_HEX_4;
      4'h5: s = SEG_HEX_5;
      4'h6: s = SEG_HEX_6;
      4'h7: s = SEG_HEX_7;
      4'h8: s = SEG_HEX_8;
      4'h9: s = SEG_HEX_9;
      4'hA: s = SEG_HEX_A;
      4'hB: s = SEG_HEX_B;
      4'hC: s = SEG_HEX_C;
      4'hD: s = SEG_HEX_D;
      4'hE: s = SEG_HEX_E;
      default: s = SEG_HEX_F;
    endcase
    return s;
  endfunction

  // Converts an active-high segment pattern to pin level.
  function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] seg_ah,
                                                    input logic            active_low);
    return active_low ? ~seg_ah : seg_ah;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment decoder with a blanking override.
module seg7_hex_decode
  import seg_mux_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  input  logic                blank_i,
  output logic [SEG_W-1:0]    seg_c
);

  assign seg_c = blank_i ? SEG_BLANK : hex_to_seg(nibble_i);

endmodule

// File: rtl/seg_mux_driver.sv
// N-digit multiplexed 7-segment driver: prescaled digit scan, blanking gap, double-buffered load.
// Optional SEGMUX_DIMMING_EN adds a brightness port that shortens the lit window.
module seg_mux_driver
  import seg_mux_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 1024,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [NIBBLE_W*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]            load_dp,
  input  logic                         lzb_en,
`ifdef SEGMUX_DIMMING_EN
  input  logic [3:0]                   brightness,
`endif
  output logic [DIGITS-1:0]            an,
  output logic [SEG_W-1:0]             seg,
  output logic                         dp,
  output logic                         frame_tick
);

  localparam int unsigned SLOT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DATA_W = NIBBLE_W * DIGITS;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]  SEG_OFF = seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW);
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;

  logic [SLOT_W-1:0] slot_cnt_q,    slot_cnt_d;
  logic [DIG_W-1:0]  digit_idx_q,   digit_idx_d;
  logic [DATA_W-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0] shadow_dp_q,   shadow_dp_d;
  logic [DATA_W-1:0] active_data_q, active_data_d;
  logic [DIGITS-1:0] active_dp_q,   active_dp_d;
  logic              pending_q,     pending_d;

  logic [DIGITS-1:0] an_q,  an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              dp_q,  dp_d;
  logic              frame_tick_q, frame_tick_d;

  logic              slot_wrap_c;
  logic              frame_end_c;
  logic              accept_c;
  logic              commit_c;
  logic              lit_c;
  logic [DIGITS-1:0] blank_vec_c;
  logic [DIGITS-1:0] an_ah_c;
  logic [NIBBLE_W-1:0] cur_nibble_c;
  logic              cur_dp_c;
  logic              cur_blank_c;
  logic [SEG_W-1:0]  seg_ah_c;

  assign slot_wrap_c = (slot_cnt_q == SLOT_LAST);
  assign frame_end_c = slot_wrap_c && (digit_idx_q == DIG_LAST);
  assign accept_c    = load_valid && !pending_q;
  // Commit looks at registered pending, so a same-cycle accept waits a full frame.
  assign commit_c    = frame_end_c && pending_q;

`ifdef SEGMUX_DIMMING_EN
  localparam int unsigned SPAN  = PRESCALE - BLANK_CYCLES;
  localparam int unsigned WIN_W = SLOT_W + 5;

  logic [WIN_W-1:0] lit_len_c;
  logic [WIN_W-1:0] lit_end_c;

  assign lit_len_c = (WIN_W'(SPAN) * (WIN_W'(brightness) + WIN_W'(1))) >> 4;
  assign lit_end_c = WIN_W'(BLANK_CYCLES) + lit_len_c;
  assign lit_c     = (slot_cnt_q >= BLANK_END) && (WIN_W'(slot_cnt_q) < lit_end_c);
`else
  assign lit_c = (slot_cnt_q >= BLANK_END);
`endif

  // Next-state for the scan counters and the two display buffers.
  always_comb begin
    slot_cnt_d    = slot_cnt_q + SLOT_W'(1);
    digit_idx_d   = digit_idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    pending_d     = pending_q;

    if (slot_wrap_c) begin
      slot_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == DIG_LAST) ? '0 : digit_idx_q + DIG_W'(1);
    end

    if (commit_c) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      pending_d     = 1'b0;
    end

    if (accept_c) begin
      shadow_data_d = load_data;
      shadow_dp_d   = load_dp;
      pending_d     = 1'b1;
    end
  end

  // Leading-zero mask, scanning from the most significant digit down; digit 0 never blanks.
  always_comb begin
    logic lead_zero;
    lead_zero   = 1'b1;
    blank_vec_c = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lead_zero = lead_zero && (active_data_q[NIBBLE_W*i +: NIBBLE_W] == 4'h0);
      if (i != 0) begin
        blank_vec_c[i] = lzb_en && lead_zero;
      end
    end
  end

  // Select the current digit's nibble, dp, blank flag and anode.
  always_comb begin
    cur_nibble_c = '0;
    cur_dp_c     = 1'b0;
    cur_blank_c  = 1'b0;
    an_ah_c      = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digit_idx_q == DIG_W'(i)) begin
        cur_nibble_c = active_data_q[NIBBLE_W*i +: NIBBLE_W];
        cur_dp_c     = active_dp_q[i];
        cur_blank_c  = blank_vec_c[i];
        an_ah_c[i]   = lit_c;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble_i (cur_nibble_c),
    .blank_i  (cur_blank_c),
    .seg_c    (seg_ah_c)
  );

  always_comb begin
    an_d         = AN_ACTIVE_LOW ? ~an_ah_c : an_ah_c;
    seg_d        = seg_polarity(seg_ah_c, SEG_ACTIVE_LOW);
    dp_d         = cur_dp_c ^ SEG_ACTIVE_LOW;
    frame_tick_d = frame_end_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      pending_q     <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      frame_tick_q  <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign load_ready = !pending_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Scoreboard bench for seg_mux_driver (4 digits, 8-cycle slots, 2-cycle blanking, active-low pins).
module tb_seg_mux_driver;

  localparam int unsigned D = 4;
  localparam int unsigned P = 8;
  localparam int unsigned B = 2;
  localparam int unsigned FRAME = P * D;

  localparam logic [6:0] SEG_LOW [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        lzb_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  logic [3:0]  bright_m;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  int          n_edge;
  logic [15:0] act_m, sh_m;
  logic [3:0]  actdp_m, shdp_m;
  logic        pend_m;

  seg_mux_driver #(
    .DIGITS         (D),
    .PRESCALE       (P),
    .BLANK_CYCLES   (B),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .lzb_en     (lzb_en),
`ifdef SEGMUX_DIMMING_EN
    .brightness (bright_m),
`endif
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", tag, n_edge, got, want);
    end
  endtask

  task automatic model_clear();
    n_edge  = 0;
    act_m   = '0;
    sh_m    = '0;
    actdp_m = '0;
    shdp_m  = '0;
    pend_m  = 1'b0;
  endtask

  // Predict the pins for the coming edge, advance the model, then compare after the edge.
  task automatic tick(input logic in_rst);
    exp_t        e;
    exp_t        got;
    int          slot, dig, litlen;
    logic [3:0]  nib;
    logic        blank;
    logic        commit, accept;
    if (in_rst) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0, rdy: 1'b1};
    end else begin
      slot   = n_edge % P;
      dig    = (n_edge / P) % D;
      litlen = ((P - B) * (int'(bright_m) + 1)) >> 4;
      e.an   = 4'hF;
      if (slot >= B && slot < B + litlen) e.an[dig] = 1'b0;
      nib   = act_m[dig*4 +: 4];
      blank = lzb_en && (dig != 0);
      for (int k = D - 1; k >= dig; k--) begin
        if (act_m[k*4 +: 4] != 4'h0) blank = 1'b0;
      end
      e.seg  = blank ? 7'h7F : SEG_LOW[nib];
      e.dp   = ~actdp_m[dig];
      e.ft   = (slot == P - 1) && (dig == D - 1);
      commit = e.ft && pend_m;
      accept = load_valid && !pend_m;
      if (commit) begin
        act_m   = sh_m;
        actdp_m = shdp_m;
        pend_m  = 1'b0;
      end
      if (accept) begin
        sh_m   = load_data;
        shdp_m = load_dp;
        pend_m = 1'b1;
      end
      e.rdy = !pend_m;
      n_edge++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = '{an: an, seg: seg, dp: dp, ft: frame_tick, rdy: load_ready};
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("an",         32'(got.an),  32'(e.an));
      check_eq("seg",        32'(got.seg), 32'(e.seg));
      check_eq("dp",         32'(got.dp),  32'(e.dp));
      check_eq("frame_tick", 32'(got.ft),  32'(e.ft));
      check_eq("load_ready", 32'(got.rdy), 32'(e.rdy));
    end
  endtask

  task automatic load_word(input logic [15:0] data, input logic [3:0] dpv);
    load_valid = 1'b1;
    load_data  = data;
    load_dp    = dpv;
    tick(1'b0);
    load_valid = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      w[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return w;
  endfunction

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    lzb_en     = 1'b0;
    bright_m   = 4'd15;
    model_clear();

    // Held in reset with the clock running.
    repeat (5) tick(1'b1);
    reset = 1'b1;

    // Scan timing over the first frame, word offered at edge 13.
    while (n_edge < 12) begin
      tick(1'b0);
      if (n_edge == 3)  check_eq("scan_e3_an",  32'(an), 32'(4'b1110));
      if (n_edge == 8)  check_eq("scan_e8_an",  32'(an), 32'(4'b1110));
      if (n_edge == 9)  check_eq("scan_e9_an",  32'(an), 32'(4'b1111));
      if (n_edge == 11) check_eq("scan_e11_an", 32'(an), 32'(4'b1101));
    end
    load_word(16'h12AF, 4'b0100);
    check_eq("ready_low_e13", 32'(load_ready), 32'd0);
    while (n_edge < 64) begin
      tick(1'b0);
      if (n_edge == 31) check_eq("ft_e31", 32'(frame_tick), 32'd0);
      if (n_edge == 31) check_eq("old_seg_e31", 32'(seg), 32'(7'b0000001));
      if (n_edge == 32) check_eq("ft_e32", 32'(frame_tick), 32'd1);
      if (n_edge == 32) check_eq("ready_e32", 32'(load_ready), 32'd1);
      if (n_edge == 35) check_eq("digit0_F", 32'(seg), 32'(7'b0111000));
      if (n_edge == 51) check_eq("digit2_2", 32'(seg), 32'(7'b0010010));
      if (n_edge == 51) check_eq("digit2_dp", 32'(dp), 32'd0);
      if (n_edge == 51) check_eq("digit2_an", 32'(an), 32'(4'b1011));
    end

    // Leading-zero blanking on 0070.
    lzb_en = 1'b1;
    load_word(16'h0070, 4'b0000);
    while (n_edge < 128) begin
      tick(1'b0);
      if (n_edge == 99)  check_eq("lzb_d0", 32'(seg), 32'(7'b0000001));
      if (n_edge == 107) check_eq("lzb_d1", 32'(seg), 32'(7'b0001111));
      if (n_edge == 115) check_eq("lzb_d2", 32'(seg), 32'(7'h7F));
      if (n_edge == 123) check_eq("lzb_d3", 32'(seg), 32'(7'h7F));
    end

    // Word accepted on the commit edge itself stays pending for a full frame.
    while (n_edge < 159) tick(1'b0);
    load_word(16'h3456, 4'b1001);
    check_eq("accept_on_commit_ready", 32'(load_ready), 32'd0);
    while (n_edge < 200) tick(1'b0);

    // Random traffic with lzb toggling.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
`ifdef SEGMUX_DIMMING_EN
      if ($urandom_range(0, 31) == 0) bright_m = 4'($urandom_range(0, 15));
`endif
      if ($urandom_range(0, 3) == 0) begin
        load_word(rand_word(), 4'($urandom_range(0, 15)));
      end else begin
        tick(1'b0);
      end
    end
    bright_m = 4'd15;

    // Pending word then asynchronous reset mid-frame.
    for (int c = 0; c < 200 && !((n_edge % FRAME) == 1 && !pend_m); c++) tick(1'b0);
    check_eq("sync_before_reset", 32'(n_edge % FRAME), 32'd1);
    load_word(16'hBEEF, 4'b1111);
    while ((n_edge % FRAME) != 20) tick(1'b0);
    check_eq("pending_before_reset", 32'(load_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_async_an",    32'(an),         32'(4'hF));
    check_eq("rst_async_seg",   32'(seg),        32'(7'h7F));
    check_eq("rst_async_dp",    32'(dp),         32'd1);
    check_eq("rst_async_ft",    32'(frame_tick), 32'd0);
    check_eq("rst_async_ready", 32'(load_ready), 32'd1);
    tick(1'b1);
    reset  = 1'b1;
    lzb_en = 1'b0;
    model_clear();
    while (n_edge < 70) begin
      tick(1'b0);
      if (n_edge == 35) check_eq("post_rst_seg", 32'(seg), 32'(7'b0000001));
      if (n_edge == 35) check_eq("post_rst_ready", 32'(load_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
